pe_seq_ctrl: RTL
================

# pe_seq_ctrl

Sequencer for a single MAC processing element (PE) with an internal 2**L_RAM_SIZE-entry operand RAM. On `start`, it clears the PE and loads the PE RAM from an external `din` source memory. It then streams the matching `ain` operands one element at a time, waiting for the PE's `dvalid` handshake after each. It returns the final accumulated `dout` with a one-cycle `done` pulse. It sits between the top-level control/memory fabric and the PE, and replaces the hand-driven stimulus sequence used in PE-level bring-up.

## Interface
Parameters:
- `SIZE`, 8, data width of ain/din/dout
- `L_RAM_SIZE`, 3, log2 of PE RAM depth; N = 2**L_RAM_SIZE elements
- `TIMEOUT`, 255, maximum cycles spent waiting for PE `dvalid` per element (8-bit counter)

Ports:
- `aclk`  in  1  clock, all logic on rising edge
- `areset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted through DONE
- `done`  out  1  one-cycle pulse at end of run (normal or timeout)
- `err`  out  1  sticky error flag, cleared when start is accepted
- `result`  out  SIZE  last PE dout captured at end of a normal run
- `mem_rd`  out  1  read strobe to source memories
- `mem_addr`  out  L_RAM_SIZE  shared read address for din/ain source memories
- `mem_din_q`  in  SIZE  din source read data, valid 1 cycle after mem_rd
- `mem_ain_q`  in  SIZE  ain source read data, valid 1 cycle after mem_rd
- `pe_aresetn`  out  1  active-low reset to PE
- `pe_we`  out  1  PE RAM write enable
- `pe_addr`  out  L_RAM_SIZE  PE RAM address
- `pe_din`  out  SIZE  PE RAM write data
- `pe_valid`  out  1  PE compute request
- `pe_ain`  out  SIZE  PE operand
- `pe_dvalid`  in  1  PE result-ready strobe
- `pe_dout`  in  SIZE  PE accumulated result

## Operation
- States: IDLE, CLR, LOAD, FETCH, ISSUE, WAIT, DONE.
- All outputs are registered and describe the current state's cycle.
- **IDLE**
  - `busy`=0.
  - `start`=1 moves to CLR and clears `err`. Element index k=0.
  - `start` in any other state is ignored.
- **CLR** (1 cycle)
  - `pe_aresetn`=0.
  - Moves to LOAD.
- **LOAD** (N+1 cycles, j=0..N)
  - For j<N: `mem_rd`=1, `mem_addr`=j.
  - For j≥1: `pe_we`=1, `pe_addr`=j-1, `pe_din`=`mem_din_q`.
  - After j=N, moves to FETCH.
- **FETCH**
  - `mem_rd`=1, `mem_addr`=k.
  - Moves to ISSUE.
- **ISSUE**
  - `pe_valid`=1, `pe_addr`=k, `pe_ain`=`mem_ain_q` for exactly one cycle.
  - Moves to WAIT and clears the timeout counter.
- **WAIT**
  - On `pe_dvalid`=1:
    - If k=N-1: capture `result`=`pe_dout` and go to DONE.
    - Otherwise: k=k+1 and go to FETCH.
  - If the counter reaches TIMEOUT without `dvalid`: set `err`=1, go to DONE, leave `result` unchanged.
- **DONE**
  - `done`=1 for one cycle.
  - Moves to IDLE.
- `pe_dvalid`=1 in any state other than WAIT is ignored for sequencing and sets `err`.
- `pe_we` and `pe_valid` are never high in the same cycle.
- Outside the cycles listed above, `pe_we`, `pe_valid` and `mem_rd` are 0.
- Address counters wrap naturally at N. No counter exceeds N.

## Timing
- Reset values:
  - FSM=IDLE.
  - `busy`=0, `done`=0, `err`=0, `result`=0.
  - `mem_rd`=0, `mem_addr`=0.
  - `pe_aresetn`=0; it rises to 1 in the first cycle after `areset` deasserts.
  - `pe_we`=0, `pe_addr`=0, `pe_din`=0, `pe_valid`=0, `pe_ain`=0.
- Latency: `start` is sampled at cycle s, with PE dvalid latency D ≥ 1 cycles after ISSUE.
  - CLR at s+1; LOAD at s+2..s+N+2.
  - FETCH of element k at s+N+3+k·(D+2).
  - `done` at s+N+3+N·(D+2). For N=8, D=3: `done` at s+51.
- Back-to-back runs: `start` held high through DONE is accepted at the following IDLE cycle.
- `areset` in any state: within one cycle, the block returns to IDLE with all reset values. The PE is held in reset via `pe_aresetn`=0. No `done` pulse is produced.

## Test plan
- Reset: assert `areset` for 3 cycles -> every output at its reset value; `pe_aresetn`=1 one cycle after release.
- Normal run:
  - Setup: N=8, din memory = k+1, ain memory = 2, behavioural PE with D=3 accumulating ain·din.
  - Expected writes: `pe_addr` 0..7 with `pe_din` 1..8 on consecutive cycles.
  - Expected issues: 8 `pe_valid` pulses with `pe_ain`=2.
  - Expected finish: `result`=72 (0x48), `done` at s+51, `err`=0.
- Start while busy: pulse `start` during WAIT of element 3 -> no effect; the run completes identically to the normal run.
- Timeout: PE never asserts `dvalid` -> after TIMEOUT cycles in WAIT of element 0, `err`=1, single `done` pulse, `result` unchanged, then IDLE.
- Spurious dvalid: drive `pe_dvalid`=1 during LOAD -> `err`=1 and the sequence continues to a correct `result`. A subsequent `start` clears `err`.
- Reset mid-run: assert `areset` during WAIT of element 4 -> IDLE with reset values and no `done`. A new `start` then gives a full correct run.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences clear, RAM load and operand streaming for one MAC PE.
// Control outputs are registered from next-state; PE data is gated straight from the source read port.
module pe_seq_ctrl #(
    parameter int SIZE       = 8,
    parameter int L_RAM_SIZE = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [SIZE-1:0]       result,
    output logic                  mem_rd,
    output logic [L_RAM_SIZE-1:0] mem_addr,
    input  logic [SIZE-1:0]       mem_din_q,
    input  logic [SIZE-1:0]       mem_ain_q,
    output logic                  pe_aresetn,
    output logic                  pe_we,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic [SIZE-1:0]       pe_din,
    output logic                  pe_valid,
    output logic [SIZE-1:0]       pe_ain,
    input  logic                  pe_dvalid,
    input  logic [SIZE-1:0]       pe_dout
);
    localparam int N = 2 ** L_RAM_SIZE;
    localparam logic [L_RAM_SIZE:0]   J_END  = (L_RAM_SIZE + 1)'(N);
    localparam logic [L_RAM_SIZE-1:0] K_LAST = L_RAM_SIZE'(N - 1);
    localparam logic [7:0]            T_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [L_RAM_SIZE:0]   j_q, j_d;
    logic [L_RAM_SIZE-1:0] k_q, k_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic [SIZE-1:0]       result_q, result_d;
    logic                  busy_q, done_q, mem_rd_q, pe_aresetn_q, pe_we_q, pe_valid_q;
    logic [L_RAM_SIZE-1:0] mem_addr_q, pe_addr_q;

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        tmo_d    = tmo_q;
        err_d    = err_q | (pe_dvalid && state_q != WAIT);
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLR;
                err_d   = 1'b0;
                j_d     = '0;
                k_d     = '0;
            end
            CLR:   state_d = LOAD;
            LOAD:  if (j_q == J_END) state_d = FETCH;
                   else j_d = j_q + (L_RAM_SIZE + 1)'(1);
            FETCH: state_d = ISSUE;
            ISSUE: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: if (pe_dvalid) begin
                if (k_q == K_LAST) begin
                    state_d  = DONE;
                    result_d = pe_dout;
                end else begin
                    state_d = FETCH;
                    k_d     = k_q + L_RAM_SIZE'(1);
                end
            end else if (tmo_q == T_LAST) begin
                state_d = DONE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so each one lines up with the state's own cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            j_q          <= '0;
            k_q          <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            pe_aresetn_q <= 1'b0;
            pe_we_q      <= 1'b0;
            pe_addr_q    <= '0;
            pe_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            k_q          <= k_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            result_q     <= result_d;
            busy_q       <= state_d != IDLE;
            done_q       <= state_d == DONE;
            mem_rd_q     <= (state_d == LOAD && j_d != J_END) || state_d == FETCH;
            mem_addr_q   <= state_d == LOAD ? j_d[L_RAM_SIZE-1:0] : state_d == FETCH ? k_d : '0;
            pe_aresetn_q <= state_d != CLR;
            pe_we_q      <= state_d == LOAD && j_d != '0;
            pe_addr_q    <= state_d == LOAD ? j_d[L_RAM_SIZE-1:0] - L_RAM_SIZE'(1) :
                            state_d == ISSUE ? k_d : '0;
            pe_valid_q   <= state_d == ISSUE;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign pe_aresetn = pe_aresetn_q;
    assign pe_we      = pe_we_q;
    assign pe_addr    = pe_addr_q;
    assign pe_valid   = pe_valid_q;
    assign pe_din     = pe_we_q ? mem_din_q : '0;
    assign pe_ain     = pe_valid_q ? mem_ain_q : '0;
endmodule
